// File: rtl/fifo_pkg.sv
// Shared helpers for the dual-clock FIFO: Gray/binary conversion and the
// legal range of synchroniser depth.
package fifo_pkg;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

  // Conversions work on a wide word; callers zero-extend in and truncate out,
  // which is exact because leading zeros do not change either mapping.
  localparam int GRAY_MAX_W = 32;
  typedef logic [GRAY_MAX_W-1:0] gray_word_t;

  function automatic gray_word_t bin2gray(input gray_word_t b);
    return (b >> 1) ^ b;
  endfunction

  function automatic gray_word_t gray2bin(input gray_word_t g);
    gray_word_t b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing clock domains.
module gray_sync
  import fifo_pkg::*;
#(
  parameter int WIDTH  = 6,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (STAGES < SYNC_STAGES_MIN || STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
    $error("gray_sync: STAGES out of range");
  end

  logic [WIDTH-1:0] sync_q [STAGES];

  // NOTE: every stage is reset, not just the last, so a stale pointer from
  // before reset can never ripple out after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= d;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/wptr_full_sync.sv
// Write-domain pointer/flag controller: binary+Gray write pointer, synchronised
// read pointer, and pessimistic full / almost-full / count / overflow flags.
module wptr_full_sync
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE    = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   rptr,
  input  logic [ADDRSIZE:0]   afull_thresh,
  input  logic                ovf_clr,
  output logic [ADDRSIZE-1:0] waddr,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wcount,
  output logic                woverflow
);

  localparam int PW = ADDRSIZE + 1;

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wgray_q, wgray_d;
  logic [PW-1:0] wcount_q;
  logic [PW-1:0] wq_rptr, rbin_s, diff;
  logic          wacc;
  logic          wfull_q, wfull_d;
  logic          waf_q, waf_d;
  logic          wovf_q, wovf_d;

  gray_sync #(
    .WIDTH (PW),
    .STAGES(SYNC_STAGES)
  ) u_rptr_sync (
    .clk  (wclk),
    .rst_n(wrst_n),
    .d    (rptr),
    .q    (wq_rptr)
  );

  // NOTE: combinational next-state uses blocking '=' so later lines see the
  // values computed above them; registers below use '<=' only.
  always_comb begin
    wacc    = winc & ~wfull_q;
    wbin_d  = wbin_q + PW'(wacc);
    wgray_d = PW'(bin2gray(gray_word_t'(wbin_d)));
    rbin_s  = PW'(gray2bin(gray_word_t'(wq_rptr)));
    diff    = wbin_d - rbin_s;
    // Full when the next write pointer is exactly one lap ahead of the read side.
    wfull_d = (wgray_d == {~wq_rptr[PW-1:PW-2], wq_rptr[PW-3:0]});
    waf_d   = (diff >= afull_thresh);
    wovf_d  = (winc & wfull_q) | (wovf_q & ~ovf_clr);
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_q   <= '0;
      wgray_q  <= '0;
      wcount_q <= '0;
      wfull_q  <= 1'b0;
      waf_q    <= 1'b0;
      wovf_q   <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wgray_q  <= wgray_d;
      wcount_q <= diff;
      wfull_q  <= wfull_d;
      waf_q    <= waf_d;
      wovf_q   <= wovf_d;
    end
  end

  assign waddr        = wbin_q[ADDRSIZE-1:0];
  assign wptr         = wgray_q;
  assign wfull        = wfull_q;
  assign walmost_full = waf_q;
  assign wcount       = wcount_q;
  assign woverflow    = wovf_q;

endmodule
